// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: round-robin arbiter that shares one single-port command RAM
// between two requesters. Each read/write transaction is sequenced into the
// RAM's two-command protocol and answered with a one-cycle response strobe.
// Optional feature macro: ADDR_CACHE_EN (skip a redundant address command
// when the RAM already holds the transaction's write/read address).
module ram_cmd_arbiter #(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned RD_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0]             req_wr_i,
    input  logic [2*ADDR_SIZE-1:0] req_addr_i,
    input  logic [2*ADDR_SIZE-1:0] req_wdata_i,
    output logic [1:0]             rsp_valid_o,
    output logic [ADDR_SIZE-1:0]   rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic [ADDR_SIZE+1:0]   ram_din_o,
    output logic                   ram_rx_valid_o,
    input  logic [ADDR_SIZE-1:0]   ram_dout_i,
    input  logic                   ram_tx_valid_i
);

    localparam int unsigned CMD_W = ADDR_SIZE + 2;
    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

    localparam logic [1:0] OP_SET_WA = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RA = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_CMD  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_RESP    = 3'd6
    } state_e;

    // FSM and captured transaction
    state_e                 state_q, state_d;
    logic                   rr_q, rr_d;
    logic                   wr_q, wr_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
    logic                   owner_q, owner_d;
    logic [ADDR_SIZE-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Registered outputs
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0]   rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;
    logic [CMD_W-1:0]       ram_din_q, ram_din_d;
    logic                   ram_rx_valid_q, ram_rx_valid_d;

    // Grant selection
    logic                   gnt_vld_c;
    logic                   gnt_idx_c;
    logic [ADDR_SIZE-1:0]   gnt_addr_c;
    logic [ADDR_SIZE-1:0]   gnt_wdata_c;
    logic                   wr_hit_c;
    logic                   rd_hit_c;

    // Single valid requester wins; on contention the round-robin pointer decides.
    assign gnt_idx_c   = (&req_valid_i) ? rr_q : req_valid_i[1];
    assign gnt_vld_c   = (state_q == S_IDLE) && (|req_valid_i) && !rst;
    assign gnt_addr_c  = gnt_idx_c ? req_addr_i[2*ADDR_SIZE-1:ADDR_SIZE]
                                   : req_addr_i[ADDR_SIZE-1:0];
    assign gnt_wdata_c = gnt_idx_c ? req_wdata_i[2*ADDR_SIZE-1:ADDR_SIZE]
                                   : req_wdata_i[ADDR_SIZE-1:0];

    // Accept strobe, combinational from state and valid; held low during reset.
    always_comb begin
        req_ready_o = 2'b00;
        if (gnt_vld_c) begin
            req_ready_o[gnt_idx_c] = 1'b1;
        end
    end

`ifdef ADDR_CACHE_EN
    logic                   wa_vld_q;
    logic                   ra_vld_q;
    logic [ADDR_SIZE-1:0]   wa_q;
    logic [ADDR_SIZE-1:0]   ra_q;
    logic                   rd_timeout_c;

    assign wr_hit_c     = wa_vld_q && (wa_q == gnt_addr_c);
    assign rd_hit_c     = ra_vld_q && (ra_q == gnt_addr_c);
    assign rd_timeout_c = (state_q == S_RD_WAIT) && (state_d == S_RESP) && err_d;

    // Mirror of the RAM's address registers; a timed-out read leaves them unknown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wa_vld_q <= 1'b0;
            ra_vld_q <= 1'b0;
            wa_q     <= '0;
            ra_q     <= '0;
        end else if (rd_timeout_c) begin
            wa_vld_q <= 1'b0;
            ra_vld_q <= 1'b0;
        end else begin
            if (state_d == S_WR_ADDR) begin
                wa_vld_q <= 1'b1;
                wa_q     <= addr_d;
            end
            if (state_d == S_RD_ADDR) begin
                ra_vld_q <= 1'b1;
                ra_q     <= addr_d;
            end
        end
    end
`else
    assign wr_hit_c = 1'b0;
    assign rd_hit_c = 1'b0;
`endif

    // Next-state, transaction capture and next-output decode.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        owner_d        = owner_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        rsp_valid_d    = 2'b00;
        rsp_data_d     = '0;
        rsp_err_d      = 1'b0;
        busy_d         = 1'b0;
        ram_din_d      = '0;
        ram_rx_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld_c) begin
                    rr_d    = ~gnt_idx_c;
                    owner_d = gnt_idx_c;
                    wr_d    = req_wr_i[gnt_idx_c];
                    addr_d  = gnt_addr_c;
                    wdata_d = gnt_wdata_c;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (wr_d) begin
                        state_d = wr_hit_c ? S_WR_DATA : S_WR_ADDR;
                    end else begin
                        state_d = rd_hit_c ? S_RD_CMD : S_RD_ADDR;
                    end
                end
            end
            S_WR_ADDR: state_d = S_WR_DATA;
            S_WR_DATA: state_d = S_RESP;
            S_RD_ADDR: state_d = S_RD_CMD;
            S_RD_CMD: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                if (ram_tx_valid_i) begin
                    rdata_d = ram_dout_i;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        unique case (state_d)
            S_WR_ADDR: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {OP_SET_WA, addr_d};
            end
            S_WR_DATA: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {OP_WRITE, wdata_d};
            end
            S_RD_ADDR: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {OP_SET_RA, addr_d};
            end
            S_RD_CMD: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {OP_READ, ADDR_SIZE'(0)};
            end
            S_RESP: begin
                rsp_valid_d[owner_d] = 1'b1;
                rsp_data_d           = wr_d ? '0 : rdata_d;
                rsp_err_d            = err_d;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, transaction and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rr_q           <= 1'b0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            owner_q        <= 1'b0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
            rsp_valid_q    <= 2'b00;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            owner_q        <= owner_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            busy_q         <= busy_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_err_o      = rsp_err_q;
    assign busy_o         = busy_q;
    assign ram_din_o      = ram_din_q;
    assign ram_rx_valid_o = ram_rx_valid_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Testbench for ram_cmd_arbiter: two requester drivers, a RAM stub, and a
// scoreboard of expected RAM commands and responses (ADDR_CACHE_EN aware).
`timescale 1ns/1ps
module tb_ram_cmd_arbiter;

    localparam int unsigned TMO = 4;
`ifdef ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr = 2'b00;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic [7:0]  ram_dout;
    logic        ram_tx_valid;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_wr_i       (req_wr),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .rsp_err_o      (rsp_err),
        .busy_o         (busy),
        .ram_din_o      (ram_din),
        .ram_rx_valid_o (ram_rx_valid),
        .ram_dout_i     (ram_dout),
        .ram_tx_valid_i (ram_tx_valid)
    );

    // RAM stub: read data one cycle after the read command, unless muted.
    logic [7:0] mem [256];
    logic [7:0] ram_wa, ram_ra;
    logic       ram_mute;
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00:   ram_wa <= ram_din[7:0];
                2'b01:   mem[ram_wa] <= ram_din[7:0];
                2'b10:   ram_ra <= ram_din[7:0];
                default: begin
                    ram_tx_valid <= !ram_mute;
                    ram_dout     <= mem[ram_ra];
                end
            endcase
        end
    end

    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        bit [7:0] exp_data;
        bit       exp_err;
        bit       mute;
        int       delay;
        int       hold;
    } item_t;

    typedef struct {
        int       req;
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        bit       mute;
        bit [7:0] exp_data;
        bit       exp_err;
    } vec_t;

    typedef struct {
        int       owner;
        bit [7:0] data;
        bit       err;
        int       due;
    } rsp_t;

    item_t      rq [2][$];
    item_t      cur [2];
    bit         act [2];
    rsp_t       rsp_q[$];
    logic [9:0] cmd_q[$];
    int         grant_log[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         prev_rsp = 1'b0;
    bit         c_wv, c_rv;
    bit [7:0]   c_wa, c_ra;
    vec_t       vt [13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic item_t mk(bit wr, bit [7:0] addr, bit [7:0] wdata, bit [7:0] ed,
                                 bit ee, bit mute, int delay, int hold);
        item_t it;
        it.wr = wr; it.addr = addr; it.wdata = wdata; it.exp_data = ed;
        it.exp_err = ee; it.mute = mute; it.delay = delay; it.hold = hold;
        return it;
    endfunction

    // Expected commands and response for an accepted transaction.
    task automatic accept_model(input int i, input item_t it);
        bit   hit;
        int   lat;
        rsp_t r;
        ram_mute = it.mute;
        if (it.wr) begin
            hit = CACHE && c_wv && (c_wa == it.addr);
            if (!hit) cmd_q.push_back({2'b00, it.addr});
            cmd_q.push_back({2'b01, it.wdata});
            c_wv = 1'b1; c_wa = it.addr;
            lat = hit ? 2 : 3;
        end else begin
            hit = CACHE && c_rv && (c_ra == it.addr);
            if (!hit) cmd_q.push_back({2'b10, it.addr});
            cmd_q.push_back({2'b11, 8'h00});
            c_rv = 1'b1; c_ra = it.addr;
            lat = (hit ? 3 : 4) + (it.mute ? int'(TMO) - 1 : 0);
            if (it.mute) begin
                c_wv = 1'b0; c_rv = 1'b0;
            end
        end
        r.owner = i; r.data = it.exp_data; r.err = it.exp_err; r.due = cyc + lat;
        rsp_q.push_back(r);
    endtask

    // One cycle: check outputs at the falling edge, drive requesters, record accepts.
    task automatic tick();
        rsp_t r;
        item_t t;
        @(negedge clk);
        cyc++;
        if (prev_rsp) chk("busy_after_rsp", 32'(busy), 32'd0);
        prev_rsp = (rsp_valid != 2'b00);
        if (rsp_valid != 2'b00) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_owner", 32'(rsp_valid), 32'(2'b01 << r.owner));
                chk("rsp_data", 32'(rsp_data), 32'(r.data));
                chk("rsp_err", 32'(rsp_err), 32'(r.err));
                chk("rsp_cycle", 32'(cyc), 32'(r.due));
                chk("rsp_busy", 32'(busy), 32'd1);
            end
        end
        if (ram_rx_valid) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(ram_rx_valid), 32'd0);
            else chk("ram_din", 32'(ram_din), 32'(cmd_q.pop_front()));
        end
        for (int i = 0; i < 2; i++) begin
            if (!act[i] && rq[i].size() > 0) begin
                if (rq[i][0].delay > 0) begin
                    t = rq[i][0]; t.delay--; rq[i][0] = t;
                end else begin
                    cur[i] = rq[i].pop_front(); act[i] = 1'b1;
                end
            end
            req_valid[i]       = act[i];
            req_wr[i]          = cur[i].wr;
            req_addr[8*i +: 8]  = cur[i].addr;
            req_wdata[8*i +: 8] = cur[i].wdata;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            if (act[i] && req_valid[i] && req_ready[i]) begin
                grant_log.push_back(i);
                act[i] = 1'b0;
                if (cur[i].hold > 0) chk("abort_granted", 32'(req_ready[i]), 32'd0);
                else accept_model(i, cur[i]);
            end else if (act[i] && cur[i].hold > 0) begin
                cur[i].hold--;
                if (cur[i].hold == 0) begin
                    act[i] = 1'b0;
                    chk("abort_while_busy", 32'(busy), 32'd1);
                end
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin
            tick(); k++;
        end while (k < 300 && (busy || act[0] || act[1] || rq[0].size() > 0 ||
                   rq[1].size() > 0 || rsp_q.size() > 0 || cmd_q.size() > 0));
        if (k >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got pending=%0d, expected 0", tag, rsp_q.size() + cmd_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ram_din"}, 32'(ram_din), 32'd0);
        chk({tag, "_ram_rx_valid"}, 32'(ram_rx_valid), 32'd0);
    endtask

    // Assumes rst is already high; abandons all bench state, then releases reset.
    task automatic flush_and_release();
        rq[0].delete(); rq[1].delete();
        act[0] = 1'b0; act[1] = 1'b0;
        rsp_q.delete(); cmd_q.delete(); grant_log.delete();
        c_wv = 1'b0; c_rv = 1'b0; prev_rsp = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        ram_mute = 1'b0;
        cur[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        cur[1] = cur[0];
        act[0] = 1'b0; act[1] = 1'b0;

        vt[0]  = '{req:0, wr:1, addr:8'h10, wdata:8'h5A, mute:0, exp_data:8'h00, exp_err:0};
        vt[1]  = '{req:1, wr:0, addr:8'h10, wdata:8'h00, mute:0, exp_data:8'h5A, exp_err:0};
        vt[2]  = '{req:0, wr:1, addr:8'h20, wdata:8'hC3, mute:0, exp_data:8'h00, exp_err:0};
        vt[3]  = '{req:1, wr:0, addr:8'h20, wdata:8'h00, mute:0, exp_data:8'hC3, exp_err:0};
        vt[4]  = '{req:0, wr:0, addr:8'h20, wdata:8'h00, mute:0, exp_data:8'hC3, exp_err:0};
        vt[5]  = '{req:1, wr:1, addr:8'h21, wdata:8'h7E, mute:0, exp_data:8'h00, exp_err:0};
        vt[6]  = '{req:0, wr:0, addr:8'h21, wdata:8'h00, mute:0, exp_data:8'h7E, exp_err:0};
        vt[7]  = '{req:1, wr:1, addr:8'h21, wdata:8'h11, mute:0, exp_data:8'h00, exp_err:0};
        vt[8]  = '{req:0, wr:0, addr:8'h21, wdata:8'h00, mute:0, exp_data:8'h11, exp_err:0};
        vt[9]  = '{req:1, wr:0, addr:8'hFF, wdata:8'h00, mute:1, exp_data:8'h00, exp_err:1};
        vt[10] = '{req:0, wr:0, addr:8'h21, wdata:8'h00, mute:0, exp_data:8'h11, exp_err:0};
        vt[11] = '{req:0, wr:1, addr:8'h00, wdata:8'hFF, mute:0, exp_data:8'h00, exp_err:0};
        vt[12] = '{req:1, wr:0, addr:8'h00, wdata:8'h00, mute:0, exp_data:8'hFF, exp_err:0};

        // Reset state, with both requesters asserting valid during reset.
        #1 rst = 1'b1;
        req_valid = 2'b11;
        #3 check_zero("reset");
        flush_and_release();

        // Contention from reset alternates; a lone requester is granted back to back.
        for (int i = 0; i < 3; i++) begin
            rq[0].push_back(mk(1, 8'h80 + 8'(i), 8'hA0 + 8'(i), 8'h00, 0, 0, 0, 0));
            rq[1].push_back(mk(1, 8'h90 + 8'(i), 8'hB0 + 8'(i), 8'h00, 0, 0, 0, 0));
        end
        wait_done("arb");
        chk("arb_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < grant_log.size(); i++) chk("arb_grant", 32'(grant_log[i]), 32'(i % 2));
        grant_log.delete();
        for (int i = 0; i < 3; i++) rq[1].push_back(mk(1, 8'h98 + 8'(i), 8'h01, 8'h00, 0, 0, 0, 0));
        wait_done("solo");
        chk("solo_count", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < grant_log.size(); i++) chk("solo_grant", 32'(grant_log[i]), 32'd1);

        // Table-driven transactions, one at a time.
        for (int v = 0; v < 13; v++) begin
            rq[vt[v].req].push_back(mk(vt[v].wr, vt[v].addr, vt[v].wdata, vt[v].exp_data,
                                       vt[v].exp_err, vt[v].mute, 0, 0));
            wait_done("vec");
        end

        // Asynchronous reset while the write-data command is on the bus.
        rq[0].push_back(mk(1, 8'h40, 8'h99, 8'h00, 0, 0, 0, 0));
        k = 0;
        do begin
            tick(); k++;
        end while (k < 50 && !(ram_rx_valid && ram_din[9:8] == 2'b01));
        chk("rst_reach_wr_data", 32'(ram_din), 32'h199);
        #1 rst = 1'b1;
        req_valid = 2'b11;
        #1 check_zero("rst_mid");
        flush_and_release();
        rq[0].push_back(mk(1, 8'h40, 8'h77, 8'h00, 0, 0, 0, 0));
        wait_done("post_rst_wr");
        rq[1].push_back(mk(0, 8'h40, 8'h00, 8'h77, 0, 0, 0, 0));
        wait_done("post_rst_rd");

        // A request withdrawn while busy is never granted and never answered.
        grant_log.delete();
        rq[0].push_back(mk(1, 8'h50, 8'h12, 8'h00, 0, 0, 0, 0));
        rq[1].push_back(mk(0, 8'h50, 8'h00, 8'h00, 0, 0, 1, 2));
        wait_done("abort");
        chk("abort_grants", 32'(grant_log.size()), 32'd1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
